// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied over XLEN shift-add steps into a
// 2*XLEN product, and the sign is applied once at the end.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as the shifted
// multiplier has run out of set bits, giving data-dependent latency.
// The last RUN cycle is a finalize cycle. It applies the sign, loads result and
// drops busy, so done appears one edge later.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   prod;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                sel_hi;
  logic                fin;
  logic                rs1_signed;
  logic                rs2_signed;
  logic [2*XLEN-1:0]   prod_fixed;

  // Two's-complement magnitude. The most negative value maps onto 2^(XLEN-1) unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic is_signed);
    logic signed [XLEN-1:0] sv;
    sv = $signed(v);
    if (is_signed && sv < 0)
      return XLEN'(-sv);
    else
      return v;
  endfunction

  // Restore the sign of the full-width product (modulo 2^(2*XLEN)).
  function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                   input logic n);
    if (n)
      return ~p + (2*XLEN)'(1);
    else
      return p;
  endfunction

  // MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
  assign rs1_signed = (op != 2'b11);
  assign rs2_signed = ~op[1];

  // All iterations are done. The early-exit form also stops once no multiplier bits remain.
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign fin = (cnt == CNT_W'(XLEN)) || ((cnt != '0) && (mplier == '0));
`else
  assign fin = (cnt == CNT_W'(XLEN));
`endif

  assign prod_fixed = apply_sign(prod, neg);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic: start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fin)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy covers the iteration cycles; done marks the single DONE cycle.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = ~fin;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands in IDLE, shift-add in RUN, load result on the finalize cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
      result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= {{XLEN{1'b0}}, magnitude(rs1, rs1_signed)};
            mplier <= magnitude(rs2, rs2_signed);
            prod   <= '0;
            cnt    <= '0;
            neg    <= (rs1_signed & rs1[XLEN-1]) ^ (rs2_signed & rs2[XLEN-1]);
            sel_hi <= (op != 2'b00);
          end
        end
        RUN: begin
          if (!fin) begin
            if (mplier[0])
              prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end else begin
            result <= sel_hi ? prod_fixed[2*XLEN-1:XLEN] : prod_fixed[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed bench for seq_multiplier with a result/latency scoreboard.
module tb_seq_multiplier;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  seq_multiplier #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product via 64-bit modular arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] p;
    a64 = (o != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    b64 = (o[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = a64 * b64;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Number of RUN iterations the design should take.
  function automatic int model_k(input logic [1:0] o, input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [31:0] m;
    int k;
    m = (o[1] == 1'b0 && b[31]) ? (~b + 32'd1) : b;
    k = 1;
    for (int i = 0; i < 32; i++)
      if (m[i]) k = i + 1;
    return k;
`else
    return 32;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    int busy_cnt;
    int lat;
    logic [31:0] e;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    exp_q.push_back(model_result(o, a, b));
    lat_q.push_back(model_k(o, b) + 1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (n < 100) begin
      if (done) break;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "_result"}, result, e);
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_result_hold"}, result, e);
  endtask

  initial begin
    int done_cnt;
    int busy_re;
    logic seen_done;
    logic [31:0] e;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mulhu_ff_const", result, 32'hFFFFFFFE);
    run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mul_ff_const", result, 32'h00000001);
    run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000);
    check("mulh_min_const", result, 32'h40000000);
    run_op("mul_min", 2'b00, 32'h80000000, 32'h80000000);
    check("mul_min_const", result, 32'h00000000);
    run_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'h00000002);
    check("mulhsu_m1_const", result, 32'hFFFFFFFF);
    run_op("mulh_m7", 2'b01, 32'hFFFFFFF9, 32'h00000003);
    check("mulh_m7_const", result, 32'hFFFFFFFF);
    run_op("mul_m7", 2'b00, 32'hFFFFFFF9, 32'h00000003);
    check("mul_m7_const", result, 32'hFFFFFFEB);
    run_op("mul_7x3", 2'b00, 32'd7, 32'd3);
    run_op("mul_7x0", 2'b00, 32'd7, 32'd0);
    run_op("mulhu_top", 2'b11, 32'h12345678, 32'h80000000);
    for (int i = 0; i < 4; i++)
      run_op("random", 2'(i), $urandom, $urandom);

    // Handshake: extra start pulses in RUN and in DONE must be ignored.
    @(negedge clk);
    op = 2'b00; rs1 = 32'd7; rs2 = 32'd3; start = 1'b1;
    exp_q.push_back(32'd21);
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; busy_re = 0; seen_done = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (seen_done && busy) busy_re++;
      if (done) begin
        done_cnt++;
        if (!seen_done) begin
          e = exp_q.pop_front();
          check("hs_result", result, e);
        end
        seen_done = 1'b1;
        start = 1'b1; rs1 = 32'd9;
      end else if (c == 2) begin
        start = 1'b1; rs1 = 32'd9;
      end
    end
    start = 1'b0;
    check("hs_done_count", done_cnt, 1);
    check("hs_busy_reassert", busy_re, 0);
    check("hs_result_after", result, 32'd21);

    // Reset abort in the middle of RUN.
    @(negedge clk);
    op = 2'b00; rs1 = 32'd5; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_op("after_abort", 2'b00, 32'd5, 32'd5);
    check("after_abort_const", result, 32'd25);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
